// File: rtl/spi_serf_if.sv
// spi_serf_if: SPI pins plus the response/receive word handshake of the SPI serf
interface spi_serf_if #(parameter int DATA_W = 16);
  logic              ss_n;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] rx_data;
  logic              rx_rdy;
  logic              frm_err;
  logic              busy;
  modport master (output ss_n, sclk, mosi, tx_data, input miso, rx_data, rx_rdy, frm_err, busy);
  modport slave  (input ss_n, sclk, mosi, tx_data, output miso, rx_data, rx_rdy, frm_err, busy);
endinterface

// File: rtl/spi_serf.sv
// spi_serf: mode-3 SPI responder, one DATA_W-bit word per frame; SPI_SERF_TRISTATE_EN releases MISO while deselected
module spi_serf #(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_serf_if.slave      bus
);
  localparam int CW = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0] FULL = CW'(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t              state, state_nx;
  logic [SYNC_STAGES:0]   ss_sy, sclk_sy;
  logic [SYNC_STAGES-1:0] mosi_sy;
  logic [DATA_W-1:0]   tx_shft, rx_shft, rx_nx;
  logic [CW-1:0]       bit_cnt;
  logic                armed;
  logic                ss_fall, ss_rise, sclk_rise, sclk_fall, mosi_s, room;
  assign ss_fall   = ss_sy[SYNC_STAGES] & ~ss_sy[SYNC_STAGES-1];
  assign ss_rise   = ~ss_sy[SYNC_STAGES] & ss_sy[SYNC_STAGES-1];
  assign sclk_fall = sclk_sy[SYNC_STAGES] & ~sclk_sy[SYNC_STAGES-1];
  assign sclk_rise = ~sclk_sy[SYNC_STAGES] & sclk_sy[SYNC_STAGES-1];
  assign mosi_s    = mosi_sy[SYNC_STAGES-1];
  assign room      = bit_cnt < FULL;
  assign rx_nx     = {rx_shft[DATA_W-2:0], mosi_s};
`ifdef SPI_SERF_TRISTATE_EN
  assign bus.miso = bus.ss_n ? 1'bz : tx_shft[DATA_W-1];
`else
  assign bus.miso = tx_shft[DATA_W-1];
`endif
  // synchronizers; the extra top stage holds the previous value for edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ss_sy   <= '1;
      sclk_sy <= '1;
      mosi_sy <= '0;
    end else begin
      ss_sy   <= {ss_sy[SYNC_STAGES-1:0], bus.ss_n};
      sclk_sy <= {sclk_sy[SYNC_STAGES-1:0], bus.sclk};
      mosi_sy <= {mosi_sy[SYNC_STAGES-2:0], bus.mosi};
    end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  // next state: select fall opens a frame, select rise closes it
  always_comb
    state_nx = (state == IDLE) ? (ss_fall ? ACTIVE : IDLE) : (ss_rise ? IDLE : ACTIVE);
  // outputs decoded from state
  always_comb
    bus.busy = (state == ACTIVE);
  // frame datapath; a select rise takes priority over any same-cycle clock edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_shft     <= '0;
      rx_shft     <= '0;
      bit_cnt     <= '0;
      armed       <= 1'b0;
      bus.rx_data <= '0;
      bus.rx_rdy  <= 1'b0;
      bus.frm_err <= 1'b0;
    end else begin
      bus.rx_rdy  <= 1'b0;
      bus.frm_err <= 1'b0;
      if (state == IDLE) begin
        if (ss_fall) begin
          tx_shft <= bus.tx_data;
          rx_shft <= '0;
          bit_cnt <= '0;
          armed   <= 1'b0;
        end
      end else if (ss_rise) begin
        bus.frm_err <= (bit_cnt != FULL);
      end else if (sclk_rise && room) begin
        rx_shft <= rx_nx;
        bit_cnt <= bit_cnt + 1'b1;
        armed   <= 1'b1;
        if (bit_cnt == LAST) begin
          bus.rx_data <= rx_nx;
          bus.rx_rdy  <= 1'b1;
        end
      end else if (sclk_fall && armed && room) begin
        tx_shft <= {tx_shft[DATA_W-2:0], 1'b0};
      end
    end
endmodule

// File: tb/tb_spi_serf.sv
// tb_spi_serf: random and directed frames from a behavioural SPI monarch against a word-level model
module tb_spi_serf;
`ifdef SPI_SERF_TRISTATE_EN
  localparam bit TRI = 1'b1;
`else
  localparam bit TRI = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  spi_serf_if #(.DATA_W(16)) bus();
  spi_serf #(.DATA_W(16), .SYNC_STAGES(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0, errors = 0;
  int rdy_cnt = 0, err_cnt = 0, exp_rdy = 0, exp_err = 0;
  bit count_en = 1'b1;
  logic [15:0] exp_rx = '0;
  logic [15:0] rd;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  // count every cycle each pulse output is high, so a stretched pulse shows up as an extra count
  always @(negedge clk)
    if (rst_n && count_en) begin
      rdy_cnt += int'(bus.rx_rdy === 1'b1);
      err_cnt += int'(bus.frm_err === 1'b1);
    end
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic sel(input logic [15:0] tx);
    check("miso_z_idle", bus.miso === 1'bz, TRI);
    bus.tx_data = tx;
    bus.ss_n = 1'b0;
    clks(8);
    check("busy_on", bus.busy, 1);
    check("miso_z_act", bus.miso === 1'bz, 0);
  endtask
  task automatic sbit(input logic b);
    bus.sclk = 1'b0;
    bus.mosi = b;
    clks(8);
    rd = {rd[14:0], bus.miso};
    bus.sclk = 1'b1;
    clks(8);
  endtask
  task automatic desel();
    clks(4);
    bus.ss_n = 1'b1;
    clks(8);
    check("busy_off", bus.busy, 0);
  endtask
  task automatic frame(input logic [15:0] w, input logic [15:0] tx, input logic [15:0] tx_late, input int n);
    logic [15:0] er = '0;
    rd = '0;
    sel(tx);
    bus.tx_data = tx_late;
    for (int i = 0; i < n; i++) begin
      if (i < 16) begin
        sbit(w[15-i]);
        er = {er[14:0], tx[15-i]};
      end else begin
        sbit(1'($urandom));
        er = {er[14:0], tx[0]};
      end
    end
    desel();
    if (n >= 16) begin
      exp_rx = w;
      exp_rdy++;
    end else exp_err++;
    check("rd_data", rd, er);
    check("rx_data", bus.rx_data, exp_rx);
    check("rdy_cnt", rdy_cnt, exp_rdy);
    check("err_cnt", err_cnt, exp_err);
  endtask
  initial begin
    bus.ss_n = 1'b1;
    bus.sclk = 1'b1;
    bus.mosi = 1'b0;
    bus.tx_data = '0;
    clks(3);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_rx_rdy", bus.rx_rdy, 0);
    check("rst_frm_err", bus.frm_err, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_miso", bus.miso === (TRI ? 1'bz : 1'b0), 1);
    rst_n = 1'b1;
    clks(4);
    frame(16'hA5C3, 16'h3C5A, 16'h3C5A, 16);
    frame(16'h0001, 16'h8000, 16'h8000, 16);
    frame(16'hFFFF, 16'h7FFF, 16'h7FFF, 16);
    frame(16'h0F0F, 16'hC3C3, 16'hC3C3, 9);
    frame(16'h6E21, 16'hAAAA, 16'h5555, 16);
    frame(16'h1111, 16'h9999, 16'h9999, 0);
    frame(16'hBEEF, 16'h4321, 16'h4321, 20);
    rd = '0;
    sel(16'hDEAD);
    for (int i = 0; i < 5; i++) sbit(1'($urandom));
    count_en = 1'b0;
    rst_n = 1'b0;
    clks(2);
    check("mid_rst_rx_data", bus.rx_data, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_rx_rdy", bus.rx_rdy, 0);
    check("mid_rst_miso", bus.miso, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) sbit(1'($urandom));
    desel();
    count_en = 1'b1;
    exp_rx = '0;
    check("post_rst_rx_data", bus.rx_data, exp_rx);
    frame(16'h1234, 16'h5A5A, 16'h5A5A, 16);
    for (int k = 0; k < 12; k++) begin
      logic [15:0] w, tx;
      int n;
      w = 16'($urandom);
      tx = 16'($urandom);
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 16;
      frame(w, tx, 16'($urandom), n);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
